// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the ROM combinationally and
// registers the returned word into a valid/ready slot toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        out_misaligned,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        slot_free;
  logic        accept;

  assign rom_addr  = pc;
  assign slot_free = !out_valid || out_ready;
  assign accept    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_VECTOR;
      state          <= RUN;
      out_valid      <= 1'b0;
      out_instr      <= NOP_INSTR;
      out_pc         <= 32'h0;
      out_pc_plus4   <= 32'h4;
      out_misaligned <= 1'b0;
      fetch_count    <= 32'h0;
    end else begin
      // The handshake completes before any flush, so it is counted regardless.
      if (accept) fetch_count <= fetch_count + 32'h1;

      if (redirect_valid) begin
        pc        <= redirect_target;
        out_valid <= 1'b0;
        state     <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (slot_free) begin
              out_pc       <= pc;
              out_pc_plus4 <= pc + 32'h4;
              out_valid    <= 1'b1;
              if (pc[1:0] == 2'b00) begin
                out_instr      <= rom_data;
                out_misaligned <= 1'b0;
                pc             <= pc + 32'h4;
              end else begin
                // Misaligned target: emit a NOP fault marker and park until redirected.
                out_instr      <= NOP_INSTR;
                out_misaligned <= 1'b1;
                state          <= FAULT;
              end
            end
          end
          FAULT: begin
            if (accept) out_valid <= 1'b0;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction ROM and feeds the decoder.
- Owns the program counter and drives the ROM's combinational address input.
- Captures the returned word into a registered fetch slot with a valid/ready handshake toward decode.
- Handles branch/jump redirects, back-pressure stalls and misaligned-target faults.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word placed in out_instr for a faulting (misaligned) slot.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rom_addr  output  32  fetch address to ROM; equals pc register (combinational from register).
- rom_data  input  32  ROM word for rom_addr, valid in the same cycle.
- redirect_valid  input  1  branch/jump taken; retarget fetch this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- out_valid  output  1  fetch slot holds an instruction.
- out_ready  input  1  decoder accepts slot when out_valid && out_ready.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  address of out_instr.
- out_pc_plus4  output  32  out_pc + 4 (mod 2^32).
- out_misaligned  output  1  slot is a misaligned-fetch fault marker.
- fetch_count  output  32  number of accepted handshakes, wraps.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_VECTOR, state=RUN, out_valid=0.
  - out_instr=NOP_INSTR, out_pc=0, out_pc_plus4=4, out_misaligned=0, fetch_count=0.
  - rst has priority over every other input.
- States: RUN (fetching), FAULT (halted after misaligned fetch).
- slot_free = !out_valid || out_ready.
- Priority per edge: rst > redirect_valid > normal fetch.
- Redirect (redirect_valid=1):
  - pc <= redirect_target; out_valid <= 0 (slot flushed even if out_ready=1); state <= RUN.
  - Valid in either state; it is the only exit from FAULT.
  - fetch_count still increments if out_valid && out_ready that cycle (the handshake completed before the flush).
- RUN, no redirect, slot_free:
  - If pc[1:0]==0: out_instr<=rom_data, out_pc<=pc, out_pc_plus4<=pc+4, out_misaligned<=0, out_valid<=1, pc<=pc+4.
  - If pc[1:0]!=0: out_instr<=NOP_INSTR, out_pc<=pc, out_pc_plus4<=pc+4, out_misaligned<=1, out_valid<=1, pc unchanged, state<=FAULT.
- RUN, no redirect, !slot_free (stall): all slot registers and pc hold. rom_addr stays stable.
- FAULT, no redirect:
  - No loads; pc holds.
  - When the fault slot is accepted, out_valid<=0 and stays 0 until a redirect.
- Latency:
  - The instruction at pc is on out_* one cycle after pc is presented.
  - Sustained throughput is one instruction per cycle while out_ready=1.
  - First valid slot appears in the second cycle after rst deasserts.
  - After a redirect, the target instruction is valid 2 edges later (redirect edge, then load edge).
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), no fault on wrap.
- fetch_count: +1 on every edge where out_valid && out_ready && !rst; wraps at 2^32.
- Outputs are all registers except rom_addr, which is pc and never X after reset.
- Outputs hold their last values while out_valid=0; the decoder ignores them in that case.

Test Plan:
- Reset then out_ready=1 constant, ROM words 0x11,0x22,0x33 at 0,4,8 -> out_valid rises second cycle after reset. Slots (pc,instr) = (0,0x11),(4,0x22),(8,0x33) on consecutive cycles. fetch_count=3 after third accept.
- Back-pressure: drop out_ready for 3 cycles while slot holds pc=4 -> out_pc/out_instr/rom_addr frozen (4, 0x22, 8). On release, pc=8 slot follows next cycle, no drop or duplicate.
- Redirect to 0x100 while a slot with pc=8 is valid and out_ready=0 -> next edge out_valid=0, rom_addr=0x100. Following edge slot (0x100, mem[0x40]) valid.
- Redirect to 0x102 -> fault slot out_pc=0x102, out_instr=0x0000_0013, out_misaligned=1. After accept, out_valid=0 for 5+ cycles. Redirect to 0x200 resumes with out_misaligned=0.
- Wrap: redirect to 0xFFFF_FFFC -> slot out_pc_plus4=0, next slot out_pc=0x0000_0000, no fault.
- rst asserted mid-stall and simultaneously with redirect_valid=1 -> pc=RESET_VECTOR, out_valid=0, fetch_count=0, state RUN.
